basic_gates_unit: RTL and testbench
===================================

Name: basic_gates_unit

Overview:
- Registered bitwise logic-gate unit.
- Computes AND, OR, NOT(A), NOR, XOR, XNOR and NAND of two operand vectors, plus one op-selected result.
- Presents all results one clock after a valid input.
- Leaf utility block, used as a logic primitive and as a bring-up/teaching block in the datapath library.

Parameters:
- WIDTH, 1, bit width of operands and of every gate output (legal range 1..64).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands A/B/op_sel valid this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op_sel  input  3  selects the gate routed to sel_ga.
- out_valid  output  1  registered outputs updated by last cycle's valid input.
- and_ga  output  WIDTH  A & B.
- or_ga  output  WIDTH  A | B.
- not_ga  output  WIDTH  ~A (B ignored).
- nor_ga  output  WIDTH  ~(A | B).
- xor_ga  output  WIDTH  A ^ B.
- xnor_ga  output  WIDTH  ~(A ^ B).
- nand_ga  output  WIDTH  ~(A & B).
- sel_ga  output  WIDTH  gate selected by op_sel.

Behaviour:
- Reset: rst_n low asynchronously clears every output to 0, including out_valid, not_ga, nor_ga, xnor_ga and nand_ga. The state is held while rst_n is low. Release is synchronous to clk.
- Latency is 1 cycle. On a rising edge with in_valid=1, all eight gate outputs register the bitwise function of the current A and B, and out_valid is set to 1.
- On a rising edge with in_valid=0:
  - out_valid is cleared to 0.
  - All gate outputs hold their previous values; there is no update.
- Full throughput: back-to-back valid inputs give back-to-back valid outputs. There is no backpressure or ready signal.
- All operations are purely bitwise per bit index. There is no carry and no cross-bit interaction.
- op_sel encoding:
  - 0 AND
  - 1 OR
  - 2 NOT(A)
  - 3 NOR
  - 4 XOR
  - 5 XNOR
  - 6 NAND
  - 7 constant all-zeros
- sel_ga registers together with the other outputs and has identical latency and hold behaviour.
- X/Z on inputs while in_valid=0 must not disturb held outputs.
- Reset asserted mid-stream discards any in-flight result. The first output after reset comes one cycle after the first valid input.

Optional Feature:
- Macro BASIC_GATES_REDUCE_EN.
- When defined, three extra 1-bit registered outputs are added:
  - red_and_ga = &A
  - red_or_ga = |A
  - red_xor_ga = ^A
- These outputs have the same latency, reset value (0) and hold behaviour as the other outputs.
- When not defined, these ports and their registers do not exist, and the remaining behaviour is unchanged.

Decomposition:
- Package basic_gates_pkg holds:
  - op_sel enum typedef (OP_AND=0, OP_OR, OP_NOT, OP_NOR, OP_XOR, OP_XNOR, OP_NAND, OP_ZERO=7)
  - OP_SEL_W=3 constant
- One sub-module, basic_gates_comb: purely combinational. It computes all seven gate vectors and the op-selected vector from A, B and op_sel.
- The top level holds only the output registers, valid tracking and the optional reduction logic.

Test Plan:
- Reset: assert rst_n=0 mid-operation with outputs nonzero -> all outputs and out_valid go to 0 immediately, without waiting for a clk edge.
- WIDTH=1 truth table, driving A,B = 00,01,10,11 with in_valid=1 on consecutive cycles. Check one cycle later, with out_valid=1 on each:
  - AND = 0,0,0,1
  - OR = 0,1,1,1
  - NOT = 1,1,0,0
  - NOR = 1,0,0,0
  - XOR = 0,1,1,0
  - XNOR = 1,0,0,1
  - NAND = 1,1,1,0
- Hold: apply a valid A=1,B=0, then in_valid=0 for 3 cycles with A/B toggling -> outputs stay XOR=1, AND=0; out_valid=0 for those cycles.
- WIDTH=8: A=0xF0, B=0xAA, valid -> and=0xA0, or=0xFA, not=0x0F, nor=0x05, xor=0x5A, xnor=0xA5, nand=0x5F.
- op_sel sweep 0..7 with A=0xF0, B=0xAA (WIDTH=8) -> sel_ga = 0xA0, 0xFA, 0x0F, 0x05, 0x5A, 0xA5, 0x5F, 0x00.
- With BASIC_GATES_REDUCE_EN defined: A=0x07, valid -> red_and=0, red_or=1, red_xor=1; A=0xFF -> red_and=1, red_or=1, red_xor=0.

Source files
------------

// File: rtl/basic_gates_pkg.sv
// Shared types and constants for the basic gates unit.
package basic_gates_pkg;

    localparam int unsigned OP_SEL_W = 3;

    typedef enum logic [OP_SEL_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NAND = 3'd6,
        OP_ZERO = 3'd7
    } op_sel_e;

endpackage

// File: rtl/basic_gates_comb.sv
// Purely combinational gate bank: seven bitwise gates plus an op-selected result.
module basic_gates_comb
    import basic_gates_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [OP_SEL_W-1:0] op_sel,
    output logic [WIDTH-1:0]    and_v,
    output logic [WIDTH-1:0]    or_v,
    output logic [WIDTH-1:0]    not_v,
    output logic [WIDTH-1:0]    nor_v,
    output logic [WIDTH-1:0]    xor_v,
    output logic [WIDTH-1:0]    xnor_v,
    output logic [WIDTH-1:0]    nand_v,
    output logic [WIDTH-1:0]    sel_v
);

    assign and_v  = A & B;
    assign or_v   = A | B;
    assign not_v  = ~A;
    assign nor_v  = ~(A | B);
    assign xor_v  = A ^ B;
    assign xnor_v = ~(A ^ B);
    assign nand_v = ~(A & B);

    always_comb begin
        sel_v = '0;
        unique case (op_sel_e'(op_sel))
            OP_AND:  sel_v = and_v;
            OP_OR:   sel_v = or_v;
            OP_NOT:  sel_v = not_v;
            OP_NOR:  sel_v = nor_v;
            OP_XOR:  sel_v = xor_v;
            OP_XNOR: sel_v = xnor_v;
            OP_NAND: sel_v = nand_v;
            OP_ZERO: sel_v = '0;
        endcase
    end

endmodule

// File: rtl/basic_gates_unit.sv
// Registered bitwise gate unit, one cycle latency; outputs hold when in_valid is low.
// Define BASIC_GATES_REDUCE_EN to add registered reduction AND/OR/XOR of A.
module basic_gates_unit
    import basic_gates_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [WIDTH-1:0]    A,
    input  logic [WIDTH-1:0]    B,
    input  logic [OP_SEL_W-1:0] op_sel,
    output logic                out_valid,
    output logic [WIDTH-1:0]    and_ga,
    output logic [WIDTH-1:0]    or_ga,
    output logic [WIDTH-1:0]    not_ga,
    output logic [WIDTH-1:0]    nor_ga,
    output logic [WIDTH-1:0]    xor_ga,
    output logic [WIDTH-1:0]    xnor_ga,
    output logic [WIDTH-1:0]    nand_ga,
`ifdef BASIC_GATES_REDUCE_EN
    output logic                red_and_ga,
    output logic                red_or_ga,
    output logic                red_xor_ga,
`endif
    output logic [WIDTH-1:0]    sel_ga
);

    logic [WIDTH-1:0] and_d, or_d, not_d, nor_d, xor_d, xnor_d, nand_d, sel_d;
    logic [WIDTH-1:0] and_q, or_q, not_q, nor_q, xor_q, xnor_q, nand_q, sel_q;
    logic             valid_q;

    basic_gates_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .A      (A),
        .B      (B),
        .op_sel (op_sel),
        .and_v  (and_d),
        .or_v   (or_d),
        .not_v  (not_d),
        .nor_v  (nor_d),
        .xor_v  (xor_d),
        .xnor_v (xnor_d),
        .nand_v (nand_d),
        .sel_v  (sel_d)
    );

    // Data registers load only on valid, so X on idle inputs never reaches them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            and_q   <= '0;
            or_q    <= '0;
            not_q   <= '0;
            nor_q   <= '0;
            xor_q   <= '0;
            xnor_q  <= '0;
            nand_q  <= '0;
            sel_q   <= '0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                and_q  <= and_d;
                or_q   <= or_d;
                not_q  <= not_d;
                nor_q  <= nor_d;
                xor_q  <= xor_d;
                xnor_q <= xnor_d;
                nand_q <= nand_d;
                sel_q  <= sel_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign and_ga    = and_q;
    assign or_ga     = or_q;
    assign not_ga    = not_q;
    assign nor_ga    = nor_q;
    assign xor_ga    = xor_q;
    assign xnor_ga   = xnor_q;
    assign nand_ga   = nand_q;
    assign sel_ga    = sel_q;

`ifdef BASIC_GATES_REDUCE_EN
    logic red_and_q, red_or_q, red_xor_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_and_q <= 1'b0;
            red_or_q  <= 1'b0;
            red_xor_q <= 1'b0;
        end else if (in_valid) begin
            red_and_q <= &A;
            red_or_q  <= |A;
            red_xor_q <= ^A;
        end
    end

    assign red_and_ga = red_and_q;
    assign red_or_ga  = red_or_q;
    assign red_xor_ga = red_xor_q;
`endif

endmodule

// File: tb/tb_basic_gates_unit.sv
// Directed self-checking bench for basic_gates_unit at WIDTH=1 and WIDTH=8.
module tb_basic_gates_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] op_sel;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       v1, and1, or1, not1, nor1, xor1, xnor1, nand1, sel1;
    logic       v8;
    logic [7:0] and8, or8, not8, nor8, xor8, xnor8, nand8, sel8;
`ifdef BASIC_GATES_REDUCE_EN
    logic       ra1, ro1, rx1, ra8, ro8, rx8;
`endif

    int errors = 0;
    int checks = 0;

    basic_gates_unit #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a1),
        .B         (b1),
        .op_sel    (op_sel),
        .out_valid (v1),
        .and_ga    (and1),
        .or_ga     (or1),
        .not_ga    (not1),
        .nor_ga    (nor1),
        .xor_ga    (xor1),
        .xnor_ga   (xnor1),
        .nand_ga   (nand1),
`ifdef BASIC_GATES_REDUCE_EN
        .red_and_ga(ra1),
        .red_or_ga (ro1),
        .red_xor_ga(rx1),
`endif
        .sel_ga    (sel1)
    );

    basic_gates_unit #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a8),
        .B         (b8),
        .op_sel    (op_sel),
        .out_valid (v8),
        .and_ga    (and8),
        .or_ga     (or8),
        .not_ga    (not8),
        .nor_ga    (nor8),
        .xor_ga    (xor8),
        .xnor_ga   (xnor8),
        .nand_ga   (nand8),
`ifdef BASIC_GATES_REDUCE_EN
        .red_and_ga(ra8),
        .red_or_ga (ro8),
        .red_xor_ga(rx8),
`endif
        .sel_ga    (sel8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " v1"}, 64'(v1), 64'd0);
        chk({tag, " not1"}, 64'(not1), 64'd0);
        chk({tag, " nand1"}, 64'(nand1), 64'd0);
        chk({tag, " v8"}, 64'(v8), 64'd0);
        chk({tag, " and8"}, 64'(and8), 64'd0);
        chk({tag, " or8"}, 64'(or8), 64'd0);
        chk({tag, " not8"}, 64'(not8), 64'd0);
        chk({tag, " nor8"}, 64'(nor8), 64'd0);
        chk({tag, " xnor8"}, 64'(xnor8), 64'd0);
        chk({tag, " nand8"}, 64'(nand8), 64'd0);
        chk({tag, " sel8"}, 64'(sel8), 64'd0);
`ifdef BASIC_GATES_REDUCE_EN
        chk({tag, " red_and8"}, 64'(ra8), 64'd0);
        chk({tag, " red_or8"}, 64'(ro8), 64'd0);
`endif
    endtask

    // Truth tables indexed by {A,B}.
    logic [3:0] e_and  = 4'b1000;
    logic [3:0] e_or   = 4'b1110;
    logic [3:0] e_not  = 4'b0011;
    logic [3:0] e_nor  = 4'b0001;
    logic [3:0] e_xor  = 4'b0110;
    logic [3:0] e_xnor = 4'b1001;
    logic [3:0] e_nand = 4'b0111;
    logic [7:0] sel_exp [8] = '{8'hA0, 8'hFA, 8'h0F, 8'h05, 8'h5A, 8'hA5, 8'h5F, 8'h00};

    initial begin
        rst_n    = 1'b1;
        in_valid = 1'b0;
        op_sel   = 3'd0;
        a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        chk("idle v1", 64'(v1), 64'd0);

        // WIDTH=1 truth table, back-to-back valids.
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = 2'(i);
            in_valid = 1'b1;
            step();
            chk($sformatf("tt%0d valid", i), 64'(v1), 64'd1);
            chk($sformatf("tt%0d and", i), 64'(and1), 64'(e_and[i]));
            chk($sformatf("tt%0d or", i), 64'(or1), 64'(e_or[i]));
            chk($sformatf("tt%0d not", i), 64'(not1), 64'(e_not[i]));
            chk($sformatf("tt%0d nor", i), 64'(nor1), 64'(e_nor[i]));
            chk($sformatf("tt%0d xor", i), 64'(xor1), 64'(e_xor[i]));
            chk($sformatf("tt%0d xnor", i), 64'(xnor1), 64'(e_xnor[i]));
            chk($sformatf("tt%0d nand", i), 64'(nand1), 64'(e_nand[i]));
            chk($sformatf("tt%0d sel", i), 64'(sel1), 64'(e_and[i]));
        end

        // Hold: one valid then three idle cycles with toggling operands.
        a1 = 1'b1; b1 = 1'b0; in_valid = 1'b1;
        step();
        chk("hold load xor", 64'(xor1), 64'd1);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = ~a1; b1 = ~b1; a8 = 8'(~a8);
            step();
            chk($sformatf("hold%0d valid", i), 64'(v1), 64'd0);
            chk($sformatf("hold%0d xor", i), 64'(xor1), 64'd1);
            chk($sformatf("hold%0d and", i), 64'(and1), 64'd0);
        end

        // WIDTH=8 vector and op_sel sweep.
        a8 = 8'hF0; b8 = 8'hAA; op_sel = 3'd0; in_valid = 1'b1;
        step();
        chk("w8 valid", 64'(v8), 64'd1);
        chk("w8 and", 64'(and8), 64'hA0);
        chk("w8 or", 64'(or8), 64'hFA);
        chk("w8 not", 64'(not8), 64'h0F);
        chk("w8 nor", 64'(nor8), 64'h05);
        chk("w8 xor", 64'(xor8), 64'h5A);
        chk("w8 xnor", 64'(xnor8), 64'hA5);
        chk("w8 nand", 64'(nand8), 64'h5F);
        for (int i = 0; i < 8; i++) begin
            op_sel = 3'(i);
            step();
            chk($sformatf("sel op%0d", i), 64'(sel8), 64'(sel_exp[i]));
        end
        // sel holds while idle even if op_sel changes
        in_valid = 1'b0; op_sel = 3'd1;
        step();
        chk("sel hold", 64'(sel8), 64'h00);
        chk("sel hold valid", 64'(v8), 64'd0);

`ifdef BASIC_GATES_REDUCE_EN
        a8 = 8'h07; in_valid = 1'b1;
        step();
        chk("red07 and", 64'(ra8), 64'd0);
        chk("red07 or", 64'(ro8), 64'd1);
        chk("red07 xor", 64'(rx8), 64'd1);
        a8 = 8'hFF;
        step();
        chk("redFF and", 64'(ra8), 64'd1);
        chk("redFF or", 64'(ro8), 64'd1);
        chk("redFF xor", 64'(rx8), 64'd0);
`endif

        // Mid-stream asynchronous reset with nonzero outputs.
        a8 = 8'h3C; b8 = 8'h0F; a1 = 1'b1; b1 = 1'b1; op_sel = 3'd1; in_valid = 1'b1;
        step();
        chk("pre-reset or8", 64'(or8), 64'h3F);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        step();
        chk_all_zero("reset held");
        #2 rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        chk("post-reset idle valid", 64'(v8), 64'd0);
        chk("post-reset idle or", 64'(or8), 64'd0);
        a8 = 8'h81; b8 = 8'h18; op_sel = 3'd4; in_valid = 1'b1;
        step();
        chk("first out valid", 64'(v8), 64'd1);
        chk("first out xor", 64'(xor8), 64'h99);
        chk("first out sel", 64'(sel8), 64'h99);
        in_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
